// File: rtl/test_status_pkg.sv
// Shared definitions for the test-status responder: FSM states, register offsets, STATUS bits.
// Imported by the responder, the core's address decoder and the bench.
package test_status_pkg;

    typedef enum logic [1:0] {
        TS_IDLE    = 2'd0,
        TS_RUN     = 2'd1,
        TS_DONE    = 2'd2,
        TS_TIMEOUT = 2'd3
    } ts_state_e;

    localparam logic [63:0] TS_TOHOST_OFS = 64'h00;
    localparam logic [63:0] TS_CYCLE_OFS  = 64'h08;
    localparam logic [63:0] TS_STATUS_OFS = 64'h10;

    localparam int TS_ST_DONE    = 0;
    localparam int TS_ST_PASS    = 1;
    localparam int TS_ST_FAIL    = 2;
    localparam int TS_ST_TIMEOUT = 3;

endpackage

// File: rtl/test_status_dev.sv
// Test-status responder: TOHOST / halt-PC completion detect, run-cycle counter and timeout.
// Latency: flags one cycle after the event; rd_data one cycle after rd_en.
// Backpressure: none; every write, retire and read is accepted in the cycle it is presented.
module test_status_dev
    import test_status_pkg::*;
#(
    parameter logic [63:0] ADDR_BASE      = 64'h0000_F000,
    parameter logic [63:0] HALT_PC        = 64'h0000_001C,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [63:0]      pc_i,
    input  logic             pc_valid,
    input  logic [63:0]      gp_i,
    input  logic             dm_we,
    input  logic [63:0]      dm_addr,
    input  logic [63:0]      dm_wdata,
    input  logic             rd_en,
    input  logic [63:0]      rd_addr,
    output logic [63:0]      rd_data,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [63:0]      result_code,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [63:0] TOHOST_ADDR = ADDR_BASE + TS_TOHOST_OFS;
    localparam logic [63:0] CYCLE_ADDR  = ADDR_BASE + TS_CYCLE_OFS;
    localparam logic [63:0] STATUS_ADDR = ADDR_BASE + TS_STATUS_OFS;
    localparam logic [63:0] TO_LAST     = 64'(TIMEOUT_CYCLES) - 64'd1;

    ts_state_e        state;
    logic             tohost_wr;
    logic             tohost_odd;
    logic             halt_hit;
    logic             ev_pass;
    logic             ev_fail;
    logic [63:0]      ev_code;
    logic [63:0]      cnt_ext;
    logic [CNT_W-1:0] cnt_inc;
    logic [63:0]      status_word;

    // Even TOHOST values are not completions, so they must not mask a halt PC.
    always_comb begin
        tohost_wr  = dm_we && (dm_addr == TOHOST_ADDR);
        tohost_odd = tohost_wr && dm_wdata[0];
        halt_hit   = pc_valid && (pc_i == HALT_PC);
        ev_pass    = (tohost_odd && (dm_wdata == 64'd1)) ||
                     (!tohost_odd && halt_hit && (gp_i == 64'd0));
        ev_fail    = (tohost_odd && (dm_wdata != 64'd1)) ||
                     (!tohost_odd && halt_hit && (gp_i != 64'd0));
        ev_code    = tohost_odd ? {1'b0, dm_wdata[63:1]} : gp_i;
    end

    always_comb begin
        cnt_ext = 64'(cycle_count);
        cnt_inc = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
    end

    always_comb begin
        status_word                = '0;
        status_word[TS_ST_DONE]    = done;
        status_word[TS_ST_PASS]    = pass;
        status_word[TS_ST_FAIL]    = fail;
        status_word[TS_ST_TIMEOUT] = timeout;
    end

    // run has priority over everything, from any state including RUN itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= TS_IDLE;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            result_code <= '0;
            cycle_count <= '0;
        end else if (run) begin
            state       <= TS_RUN;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            result_code <= '0;
            cycle_count <= '0;
        end else if (state == TS_RUN) begin
            cycle_count <= cnt_inc;
            if (ev_pass) begin
                state <= TS_DONE;
                done  <= 1'b1;
                pass  <= 1'b1;
            end else if (ev_fail) begin
                state       <= TS_DONE;
                done        <= 1'b1;
                fail        <= 1'b1;
                result_code <= ev_code;
            end else if (cnt_ext == TO_LAST) begin
                state   <= TS_TIMEOUT;
                timeout <= 1'b1;
            end
        end
    end

    // Reads see the flags as registered, i.e. the status before any same-cycle event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (rd_addr == CYCLE_ADDR) begin
                rd_data <= cnt_ext;
            end else if (rd_addr == STATUS_ADDR) begin
                rd_data <= status_word;
            end else begin
                rd_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_test_status_dev.sv
// Bench for test_status_dev: directed plan steps plus a random phase against a rule-level model.
module tb_test_status_dev;
    import test_status_pkg::*;

    localparam logic [63:0] BASE = 64'h0000_F000;
    localparam logic [63:0] HALT = 64'h0000_001C;
    localparam int          TO   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [63:0] pc_i = '0;
    logic        pc_valid = 1'b0;
    logic [63:0] gp_i = '0;
    logic        dm_we = 1'b0;
    logic [63:0] dm_addr = '0;
    logic [63:0] dm_wdata = '0;
    logic        rd_en = 1'b0;
    logic [63:0] rd_addr = '0;
    logic [63:0] rd_data;
    logic        done, pass, fail, timeout;
    logic [63:0] result_code;
    logic [31:0] cycle_count;

    // reference model state
    logic        m_live;
    logic        m_done, m_pass, m_fail, m_to;
    logic [63:0] m_code;
    logic [31:0] m_cnt;
    logic [63:0] m_rd;

    int total = 0;
    int bad   = 0;

    test_status_dev #(
        .ADDR_BASE(BASE),
        .HALT_PC(HALT),
        .TIMEOUT_CYCLES(TO),
        .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .pc_i(pc_i), .pc_valid(pc_valid), .gp_i(gp_i),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .result_code(result_code), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_live = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_fail = 1'b0; m_to = 1'b0;
        m_code = '0; m_cnt = '0; m_rd = '0;
    endtask

    // One clock of the rules, applied to the inputs the DUT is about to sample.
    task automatic model_step();
        logic [63:0] st;
        bit over;
        over = 1'b0;
        st = {60'd0, m_to, m_fail, m_pass, m_done};
        if (rd_en) begin
            if (rd_addr == BASE + 64'h8)       m_rd = 64'(m_cnt);
            else if (rd_addr == BASE + 64'h10) m_rd = st;
            else                               m_rd = '0;
        end
        if (run) begin
            m_live = 1'b1; m_done = 1'b0; m_pass = 1'b0; m_fail = 1'b0; m_to = 1'b0;
            m_code = '0; m_cnt = '0;
        end else if (m_live) begin
            if (dm_we && dm_addr == BASE && dm_wdata == 64'd1) begin
                m_pass = 1'b1; over = 1'b1;
            end else if (dm_we && dm_addr == BASE && (dm_wdata % 2) == 64'd1) begin
                m_fail = 1'b1; m_code = dm_wdata / 2; over = 1'b1;
            end else if (pc_valid && pc_i == HALT) begin
                if (gp_i == 64'd0) m_pass = 1'b1;
                else begin m_fail = 1'b1; m_code = gp_i; end
                over = 1'b1;
            end else if (m_cnt == 32'(TO - 1)) begin
                m_to = 1'b1; over = 1'b1;
            end
            m_done = m_pass | m_fail;
            if (over) m_live = 1'b0;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".done"},    64'(done),        64'(m_done));
        chk({tag, ".pass"},    64'(pass),        64'(m_pass));
        chk({tag, ".fail"},    64'(fail),        64'(m_fail));
        chk({tag, ".timeout"}, 64'(timeout),     64'(m_to));
        chk({tag, ".code"},    result_code,      m_code);
        chk({tag, ".cycles"},  64'(cycle_count), 64'(m_cnt));
        chk({tag, ".rd_data"}, rd_data,          m_rd);
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_in();
        run = 1'b0; dm_we = 1'b0; pc_valid = 1'b0; rd_en = 1'b0;
        dm_addr = BASE; dm_wdata = '0; pc_i = '0; gp_i = '0;
    endtask

    task automatic run_pulse(input string tag);
        idle_in();
        run = 1'b1;
        cycle(tag);
        run = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.cycles", 64'(cycle_count), 64'd0);
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // completions outside RUN are ignored
        idle_in();
        dm_we = 1'b1; dm_wdata = 64'd1; pc_valid = 1'b1; pc_i = HALT;
        cycle("idle_ignore");
        chk("idle_ignore.done", 64'(done), 64'd0);

        // pass via TOHOST at cycle 10
        run_pulse("a.run");
        repeat (10) cycle("a.wait");
        chk("a.cnt10", 64'(cycle_count), 64'd10);
        dm_we = 1'b1; dm_addr = BASE; dm_wdata = 64'd1;
        cycle("a.hit");
        idle_in();
        chk("a.done", 64'(done), 64'd1);
        chk("a.pass", 64'(pass), 64'd1);
        chk("a.fail", 64'(fail), 64'd0);
        chk("a.cnt11", 64'(cycle_count), 64'd11);
        cycle("a.frozen");
        chk("a.frozen11", 64'(cycle_count), 64'd11);
        rd_en = 1'b1; rd_addr = BASE + 64'h10;
        cycle("a.rd_status");
        chk("a.status3", rd_data, 64'h3);
        rd_addr = BASE + 64'h18;
        cycle("a.rd_unmapped");
        chk("a.unmapped0", rd_data, 64'h0);
        rd_addr = BASE + 64'h8;
        cycle("a.rd_cycle");
        chk("a.cycle11", rd_data, 64'd11);
        rd_en = 1'b0;
        cycle("a.rd_hold");
        chk("a.rd_hold11", rd_data, 64'd11);
        rd_en = 1'b1; rd_addr = BASE;
        cycle("a.rd_tohost");
        chk("a.tohost0", rd_data, 64'd0);

        // fail via TOHOST 7
        run_pulse("b.run");
        repeat (3) cycle("b.wait");
        dm_we = 1'b1; dm_wdata = 64'h7;
        cycle("b.hit");
        idle_in();
        chk("b.fail", 64'(fail), 64'd1);
        chk("b.code3", result_code, 64'd3);

        // even TOHOST ignored, then halt with gp=0
        run_pulse("c.run");
        dm_we = 1'b1; dm_wdata = 64'h4;
        cycle("c.even");
        idle_in();
        chk("c.even_done", 64'(done), 64'd0);
        repeat (2) cycle("c.wait");
        pc_valid = 1'b1; pc_i = HALT; gp_i = 64'd0;
        cycle("c.halt");
        idle_in();
        chk("c.pass", 64'(pass), 64'd1);
        chk("c.cnt4", 64'(cycle_count), 64'd4);

        // halt with gp=5
        run_pulse("d.run");
        pc_valid = 1'b1; pc_i = HALT; gp_i = 64'h5;
        cycle("d.halt");
        idle_in();
        chk("d.fail", 64'(fail), 64'd1);
        chk("d.code5", result_code, 64'd5);

        // timeout after 16 RUN cycles
        run_pulse("e.run");
        repeat (15) cycle("e.wait");
        chk("e.not_yet", 64'(timeout), 64'd0);
        cycle("e.edge");
        chk("e.timeout", 64'(timeout), 64'd1);
        chk("e.done0", 64'(done), 64'd0);
        chk("e.cnt16", 64'(cycle_count), 64'd16);
        pc_valid = 1'b1; pc_i = HALT;
        cycle("e.late_halt");
        idle_in();
        chk("e.late_done0", 64'(done), 64'd0);

        // TOHOST 3 and halt together: TOHOST wins
        run_pulse("f.run");
        dm_we = 1'b1; dm_wdata = 64'h3; pc_valid = 1'b1; pc_i = HALT; gp_i = 64'd0;
        cycle("f.both");
        idle_in();
        chk("f.fail", 64'(fail), 64'd1);
        chk("f.pass0", 64'(pass), 64'd0);
        chk("f.code1", result_code, 64'd1);

        // halt on the timeout boundary: completion wins
        run_pulse("g.run");
        repeat (15) cycle("g.wait");
        pc_valid = 1'b1; pc_i = HALT; gp_i = 64'd0;
        cycle("g.edge");
        idle_in();
        chk("g.pass", 64'(pass), 64'd1);
        chk("g.timeout0", 64'(timeout), 64'd0);

        // run and completion together: run wins
        run_pulse("h.run");
        repeat (5) cycle("h.wait");
        run = 1'b1; dm_we = 1'b1; dm_wdata = 64'd1;
        cycle("h.both");
        idle_in();
        chk("h.done0", 64'(done), 64'd0);
        chk("h.cnt0", 64'(cycle_count), 64'd0);

        // random traffic
        run_pulse("r.run");
        for (int i = 0; i < 500; i++) begin
            run      = ($urandom_range(0, 39) == 0);
            dm_we    = ($urandom_range(0, 9) == 0);
            dm_addr  = ($urandom_range(0, 3) == 0) ? BASE + 64'h8 : BASE;
            dm_wdata = 64'($urandom_range(0, 7));
            pc_valid = ($urandom_range(0, 1) == 1);
            pc_i     = ($urandom_range(0, 11) == 0) ? HALT : 64'($urandom_range(0, 15) * 4);
            gp_i     = 64'($urandom_range(0, 2));
            rd_en    = ($urandom_range(0, 1) == 1);
            rd_addr  = BASE + 64'($urandom_range(0, 3) * 8);
            cycle("rand");
        end

        // asynchronous reset mid-RUN
        run_pulse("x.run");
        repeat (4) cycle("x.wait");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("x.done0", 64'(done), 64'd0);
        chk("x.cnt0", 64'(cycle_count), 64'd0);
        chk("x.rd0", rd_data, 64'd0);
        check_all("x.async");
        @(negedge clk);
        rst = 1'b1;
        cycle("x.idle");
        chk("x.idle_cnt", 64'(cycle_count), 64'd0);
        run_pulse("x.rerun");
        chk("x.rerun_cnt0", 64'(cycle_count), 64'd0);
        cycle("x.count");
        chk("x.rerun_cnt1", 64'(cycle_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/test_status_dev.md
# test_status_dev

Memory-mapped test-status responder on the data-memory bus of the RV64I core. It is the hardware end of the simulation pass/fail handshake. The core reports completion in one of two ways: a store to a `TOHOST` register, or reaching the halt PC with the result held in `gp` (x3). The block counts run cycles, enforces a cycle timeout, and presents registered `done`/`pass`/`fail`/`timeout` flags plus a result code to the bench or board logic.

## Interface
Parameters:
- `ADDR_BASE`, 64'h0000_F000, base of the 3-register window (8-byte aligned).
- `HALT_PC`, 64'h0000_001C, PC whose retirement ends the test.
- `TIMEOUT_CYCLES`, 100000, maximum RUN cycles before `timeout`.
- `CNT_W`, 32, width of the cycle counter.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `run` in 1: start pulse; clears all status and enters RUN.
- `pc_i` in 64: PC of the instruction retiring this cycle.
- `pc_valid` in 1: `pc_i` is valid.
- `gp_i` in 64: current value of register x3.
- `dm_we` in 1: data-memory write strobe (full 64-bit store).
- `dm_addr` in 64: data-memory address.
- `dm_wdata` in 64: store data.
- `rd_en` in 1: read request.
- `rd_addr` in 64: read address.
- `rd_data` out 64: read data, 1-cycle latency.
- `done` out 1: test finished, either by pass or by fail.
- `pass` out 1: test passed.
- `fail` out 1: test failed.
- `timeout` out 1: cycle limit reached.
- `result_code` out 64: failing test number, or the nonzero `gp` value.
- `cycle_count` out CNT_W: RUN cycles elapsed.

## Operation
- Register map, relative to `ADDR_BASE`:
  - +0x00 `TOHOST`: write-only; reads as 0.
  - +0x08 `CYCLE`: read-only; returns `cycle_count` zero-extended.
  - +0x10 `STATUS`: read-only; bit0 `done`, bit1 `pass`, bit2 `fail`, bit3 `timeout`, all other bits 0.
- Addresses are decoded by full 64-bit compare. Unmapped reads return 0. Writes to any address other than `TOHOST` are ignored.
- FSM states are IDLE, RUN, DONE, TIMEOUT. Reset enters IDLE.
- IDLE → RUN on `run`.
- RUN → DONE on a completion event:
  - `TOHOST` write with `dm_wdata==1`: pass.
  - `TOHOST` write with odd `dm_wdata` other than 1: fail, `result_code = dm_wdata>>1`.
  - `TOHOST` write with even `dm_wdata`: ignored, no state change.
  - `pc_valid && pc_i==HALT_PC`: pass if `gp_i==0`; otherwise fail with `result_code=gp_i`.
- RUN → TIMEOUT when `cycle_count==TIMEOUT_CYCLES-1` and no completion event occurs that cycle.
- DONE or TIMEOUT → RUN on `run`. This clears flags, `result_code`, and `cycle_count`.
- `run` while already in RUN restarts the counter and stays in RUN.
- Simultaneous events:
  - A `TOHOST` write and a halt PC in the same cycle: `TOHOST` wins.
  - A completion and the timeout boundary in the same cycle: completion wins.
  - `run` and a completion in the same cycle: `run` wins.
- `TOHOST` writes and halt PCs outside RUN are ignored.
- Flags and `result_code` hold until the next `run` or reset.
- `pass` and `fail` are mutually exclusive. `done` is high iff `pass || fail`. `timeout` is never high together with `done`.

## Timing
- Reset values: `done`, `pass`, `fail`, `timeout` = 0; `result_code`, `rd_data`, `cycle_count` = 0. Reset mid-RUN aborts to IDLE immediately (asynchronous).
- `cycle_count`:
  - Reads 0 in the cycle after `run` is sampled.
  - Increments by 1 per RUN cycle.
  - Freezes on leaving RUN.
  - Saturates at all-ones if `CNT_W` is narrower than needed.
- Flags are registered and become visible the cycle after the triggering event is sampled.
- `rd_data` is registered: valid the cycle after `rd_en`. It holds its previous value when `rd_en` is low.
- A read of `STATUS` in the same cycle as a completion event returns the pre-event status.

## Structure
- `test_status_pkg` holds:
  - the state enum `ts_state_e`;
  - register offsets `TS_TOHOST_OFS`, `TS_CYCLE_OFS`, `TS_STATUS_OFS`;
  - STATUS bit indices.
- The bench and the core's address decoder import the same package.
- Single module; no sub-module is needed. The counter and FSM are inline.

## Test plan
- `run`, then `TOHOST` write of 1 at cycle 10 → next cycle `done=1`, `pass=1`, `fail=0`; `cycle_count` frozen at 11.
- `run`, then `TOHOST` write of 0x7 → `fail=1`, `result_code=3`.
- `run`, then `TOHOST` write of 0x4 → no change, remains in RUN.
- `run`, then `pc_i=0x1C` with `pc_valid`:
  - `gp_i=0` → `pass=1`.
  - Repeated with `gp_i=0x5` → `fail=1`, `result_code=5`.
- `TIMEOUT_CYCLES=16`, `run`, no events → `timeout=1` after 16 RUN cycles, `done=0`.
- Same cycle: `TOHOST` write of 0x3 plus halt PC with `gp_i=0` → `fail=1`, `result_code=1`.
- Same cycle: halt PC plus timeout boundary → `pass=1`, `timeout=0`.
- Read `STATUS` after pass → `rd_data=0x3` one cycle later.
- Read unmapped `ADDR_BASE+0x18` → 0.
- Reset asserted mid-RUN → all outputs 0 asynchronously; state IDLE; a later `run` restarts with `cycle_count` 0.
